// File: rtl/alu_mdu_iter.sv
// Execute-stage ALU with an iterative radix-2 multiply/divide unit behind valid/ready.
// Optional: ALU_MDU_ITER_EARLY_OUT_EN lets M ops with a zero operand skip the BUSY iterations.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | one shift-add / shift-subtract step per cycle
// DONE  | result presented, held until out_ready
module alu_mdu_iter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] acc, lo, mcand;
  logic [SHW-1:0]   cnt;
  logic             m_div, sel_hi, neg;

  logic accept, is_m, early;
  assign is_m      = op[4];
  assign in_ready  = !flush && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);

  // Single adder: base ADD/SUB outside BUSY, iteration step inside BUSY.
  logic [WIDTH:0]   add_x, add_y;
  logic             add_sub;
  logic [WIDTH+1:0] add_sum;

  always_comb begin
    add_x   = {1'b0, a};
    add_y   = {1'b0, b};
    add_sub = (op[3:0] == 4'b1000);
    if (state == S_BUSY) begin
      if (m_div) begin
        add_x   = {acc, lo[WIDTH-1]};
        add_y   = {1'b0, mcand};
        add_sub = 1'b1;
      end else begin
        add_x   = {1'b0, acc};
        add_y   = lo[0] ? {1'b0, mcand} : '0;
        add_sub = 1'b0;
      end
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y ^ {(WIDTH+1){add_sub}}}
                 + {{(WIDTH+1){1'b0}}, add_sub};

  logic             ge;
  logic [WIDTH-1:0] acc_step, lo_step;

  always_comb begin
    ge       = add_sum[WIDTH+1];
    acc_step = add_sum[WIDTH:1];
    lo_step  = {add_sum[0], lo[WIDTH-1:1]};
    if (m_div) begin
      acc_step = ge ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
      lo_step  = {lo[WIDTH-2:0], ge};
    end
  end

  // Sign correction on the final step; quotient/remainder ride in the low half.
  logic [2*WIDTH-1:0] fin_val, fin_sgn;
  logic [WIDTH-1:0]   m_result;

  always_comb begin
    fin_val  = m_div ? {{WIDTH{1'b0}}, (sel_hi ? acc_step : lo_step)} : {acc_step, lo_step};
    fin_sgn  = neg ? -fin_val : fin_val;
    m_result = (!m_div && sel_hi) ? fin_sgn[2*WIDTH-1:WIDTH] : fin_sgn[WIDTH-1:0];
  end

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_res;
  logic             base_c;
  assign shamt = b[SHW-1:0];

  always_comb begin
    base_res = '0;
    base_c   = 1'b0;
    case (op[3:0])
      4'b0000, 4'b1000: begin
        base_res = add_sum[WIDTH-1:0];
        base_c   = add_sum[WIDTH];
      end
      4'b0111: base_res = a & b;
      4'b0110: base_res = a | b;
      4'b0100: base_res = a ^ b;
      4'b0001: base_res = a << shamt;
      4'b0101: base_res = a >> shamt;
      4'b1101: base_res = $signed(a) >>> shamt;
      default: ;
    endcase
  end

  logic             signed_a, signed_b, sa, sb, b_zero, neg_nx, sel_hi_nx;
  logic [WIDTH-1:0] mag_a, mag_b, early_res;

  always_comb begin
    signed_a  = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    signed_b  = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    sa        = signed_a && a[WIDTH-1];
    sb        = signed_b && b[WIDTH-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
    b_zero    = (b == '0);
    // Remainder follows the dividend; quotient is negative only for a nonzero divisor.
    neg_nx    = op[2] ? (op[1] ? sa : ((sa ^ sb) && !b_zero)) : (sa ^ sb);
    sel_hi_nx = op[2] ? op[1] : (op[1:0] != 2'b00);
    early_res = (op[2] && b_zero) ? (op[1] ? a : '1) : '0;
  end

`ifdef ALU_MDU_ITER_EARLY_OUT_EN
  assign early = b_zero || (a == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (is_m && !early) ? S_BUSY : S_DONE;
      S_BUSY: if (cnt == '0) state_nx = S_DONE;
      S_DONE: begin
        if (accept)         state_nx = (is_m && !early) ? S_BUSY : S_DONE;
        else if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      cout   <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      m_div  <= 1'b0;
      sel_hi <= 1'b0;
      neg    <= 1'b0;
    end else if (accept) begin
      if (!is_m) begin
        result <= base_res;
        cout   <= base_c;
      end else if (early) begin
        result <= early_res;
        cout   <= 1'b0;
      end else begin
        m_div  <= op[2];
        sel_hi <= sel_hi_nx;
        neg    <= neg_nx;
        acc    <= '0;
        lo     <= op[2] ? mag_a : mag_b;
        mcand  <= op[2] ? mag_b : mag_a;
        cnt    <= SHW'(WIDTH-1);
      end
    end else if ((state == S_BUSY) && !flush) begin
      acc <= acc_step;
      lo  <= lo_step;
      cnt <= cnt - SHW'(1);
      if (cnt == '0) begin
        result <= m_result;
        cout   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_iter.sv
// Scoreboard bench for alu_mdu_iter: 32-bit and 8-bit instances, directed vectors.
module tb_alu_mdu_iter;

`ifdef ALU_MDU_ITER_EARLY_OUT_EN
  localparam int LAT_Z32 = 1;
  localparam int LAT_Z8  = 1;
`else
  localparam int LAT_Z32 = 33;
  localparam int LAT_Z8  = 9;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        flush32 = 1'b0, iv32 = 1'b0, ordy32 = 1'b1;
  logic [4:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, ov32, c32, busy32;
  logic [31:0] res32;

  logic        flush8 = 1'b0, iv8 = 1'b0, ordy8 = 1'b1;
  logic [4:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, ov8, c8, busy8;
  logic [7:0]  res8;

  alu_mdu_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush32), .in_valid(iv32), .in_ready(rdy32),
    .op(op32), .a(a32), .b(b32), .out_valid(ov32), .out_ready(ordy32),
    .result(res32), .cout(c32), .busy(busy32));

  alu_mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush8), .in_valid(iv8), .in_ready(rdy8),
    .op(op8), .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8),
    .result(res8), .cout(c8), .busy(busy8));

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Latency is counted in edges from the accepting edge (inclusive) to out_valid.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset && ov32 && ordy32) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out32 actual=%h required=no_output", res32);
      end else begin
        e = q32.pop_front();
        chk({e.nm, "_result"}, res32, e.res);
        chk({e.nm, "_cout"}, 32'(c32), 32'(e.c));
        if (e.lat >= 0) chk({e.nm, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!reset && ov8 && ordy8) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out8 actual=%h required=no_output", res8);
      end else begin
        e = q8.pop_front();
        chk({e.nm, "_result"}, {24'h0, res8}, e.res);
        chk({e.nm, "_cout"}, 32'(c8), 32'(e.c));
        if (e.lat >= 0) chk({e.nm, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input bit w8, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input logic c, input int lat, input bit push,
                       input string nm);
    int n;
    @(posedge clk); #1;
    if (w8) begin op8 = o; a8 = x[7:0]; b8 = y[7:0]; iv8 = 1'b1; end
    else    begin op32 = o; a32 = x; b32 = y; iv32 = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!(w8 ? rdy8 : rdy32) && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_accept"}, 32'(w8 ? rdy8 : rdy32), 32'd1);
    @(posedge clk); #1;
    if (push) begin
      if (w8) q8.push_back('{r, c, lat, cyc, nm});
      else    q32.push_back('{r, c, lat, cyc, nm});
    end
    iv8 = 1'b0; iv32 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 500) begin @(posedge clk); n++; end
    chk("drain_q32_empty", 32'(q32.size()), 32'd0);
    chk("drain_q8_empty", 32'(q8.size()), 32'd0);
    q32.delete(); q8.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(ov32), 32'd0);
    chk("rst_result", res32, 32'd0);
    chk("rst_cout", 32'(c32), 32'd0);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_in_ready", 32'(rdy32), 32'd1);
    chk("rst8_out_valid", 32'(ov8), 32'd0);

    // base ops
    issue(0, 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1, 1, "add_wrap");
    issue(0, 5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1, 1, "add_ovf");
    issue(0, 5'b01000, 32'h3, 32'h5, 32'hFFFFFFFE, 1'b1, 1, 1, "sub_borrow");
    issue(0, 5'b01000, 32'h5, 32'h3, 32'h2, 1'b0, 1, 1, "sub_noborrow");
    issue(0, 5'b00111, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1, 1, "and");
    issue(0, 5'b00110, 32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 1'b0, 1, 1, "or");
    issue(0, 5'b00100, 32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34, 1'b0, 1, 1, "xor");
    issue(0, 5'b00001, 32'h1, 32'h24, 32'h10, 1'b0, 1, 1, "sll_mask");
    issue(0, 5'b00101, 32'h80000000, 32'h4, 32'h08000000, 1'b0, 1, 1, "srl");
    issue(0, 5'b01101, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1, 1, "sra");
    issue(0, 5'b00010, 32'h5, 32'h5, 32'h0, 1'b0, 1, 1, "illegal");

    // multiply
    issue(0, 5'b10000, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 1'b0, 33, 1, "mul");
    issue(0, 5'b10001, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 1'b0, 33, 1, "mulh");
    issue(0, 5'b10010, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 1'b0, 33, 1, "mulhsu");
    issue(0, 5'b10011, 32'hFFFFFFFD, 32'h7, 32'h00000006, 1'b0, 33, 1, "mulhu");
    issue(0, 5'b11000, 32'h00012345, 32'h100, 32'h01234500, 1'b0, 33, 1, "mul_op3");
    issue(0, 5'b10000, 32'h0, 32'h5, 32'h0, 1'b0, LAT_Z32, 1, "mul_azero");

    // divide
    issue(0, 5'b10100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 33, 1, "div_neg");
    issue(0, 5'b10110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, 33, 1, "rem_neg");
    issue(0, 5'b10101, 32'h7, 32'h0, 32'hFFFFFFFF, 1'b0, LAT_Z32, 1, "divu_zero");
    issue(0, 5'b10110, 32'h7, 32'h0, 32'h7, 1'b0, LAT_Z32, 1, "rem_zero");
    issue(0, 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33, 1, "div_ovf");
    issue(0, 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 33, 1, "rem_ovf");
    issue(0, 5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1, "divu");
    issue(0, 5'b10111, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1, "remu");

    // back-pressure, then simultaneous drain and accept
    drain();
    ordy32 = 1'b0;
    issue(0, 5'b00000, 32'h10, 32'h20, 32'h30, 1'b0, -1, 1, "add_hold");
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(ov32), 32'd1);
      chk("hold_result", res32, 32'h30);
      chk("hold_in_ready", 32'(rdy32), 32'd0);
      @(posedge clk); #1;
      a32 = a32 ^ 32'hA5A5A5A5;
      b32 = b32 ^ 32'h5A5A5A5A;
    end
    ordy32 = 1'b1;
    op32 = 5'b00111; a32 = 32'hFF00FF00; b32 = 32'h0FF00FF0; iv32 = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 32'(rdy32), 32'd1);
    chk("b2b_out_valid", 32'(ov32), 32'd1);
    @(posedge clk); #1;
    q32.push_back('{32'h0F000F00, 1'b0, 1, cyc, "and_b2b"});
    iv32 = 1'b0;

    // flush at step 10 of a division
    drain();
    issue(0, 5'b10100, 32'd1000, 32'd3, 32'h0, 1'b0, 0, 0, "div_flushed");
    repeat (9) @(posedge clk);
    #1;
    chk("flush_busy_before", 32'(busy32), 32'd1);
    flush32 = 1'b1; op32 = 5'b00000; a32 = 32'h1; b32 = 32'h1; iv32 = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(rdy32), 32'd0);
    @(posedge clk); #1;
    flush32 = 1'b0; iv32 = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(ov32), 32'd0);
    chk("flush_busy_after", 32'(busy32), 32'd0);
    chk("flush_in_ready_after", 32'(rdy32), 32'd1);
    repeat (40) @(posedge clk);
    issue(0, 5'b00000, 32'h2, 32'h3, 32'h5, 1'b0, 1, 1, "add_after_flush");

    // asynchronous reset mid-division
    drain();
    issue(0, 5'b10101, 32'd1000, 32'd3, 32'h0, 1'b0, 0, 0, "divu_reset");
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ov32), 32'd0);
    chk("arst_busy", 32'(busy32), 32'd0);
    chk("arst_result", res32, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("arst_in_ready_after", 32'(rdy32), 32'd1);
    chk("arst_out_valid_after", 32'(ov32), 32'd0);
    issue(0, 5'b00000, 32'h7, 32'h8, 32'hF, 1'b0, 1, 1, "add_after_reset");

    // 8-bit instance
    issue(1, 5'b10011, 32'hFF, 32'hFF, 32'hFE, 1'b0, 9, 1, "mulhu8");
    issue(1, 5'b10101, 32'h05, 32'h00, 32'hFF, 1'b0, LAT_Z8, 1, "divu8_zero");
    issue(1, 5'b00000, 32'hFF, 32'h01, 32'h00, 1'b1, 1, 1, "add8_wrap");
    issue(1, 5'b10100, 32'h80, 32'hFF, 32'h80, 1'b0, 9, 1, "div8_ovf");
    issue(1, 5'b10110, 32'hF9, 32'h02, 32'hFF, 1'b0, 9, 1, "rem8_neg");

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
